grf_write_arbiter: RTL and testbench
====================================

Name: grf_write_arbiter

Overview:
- Writer side of the general register file's single write port: merges in-order pipeline writebacks with out-of-order results from multi-cycle units (mult/div, HI/LO moves) into one registered write per cycle.
- Side results are buffered in a small FIFO.
- Exports a pending-register mask that the hazard unit uses to stall readers of registers whose writes are still queued.
- Sits between the W stage / multi-cycle unit and the register file's writeAddress/writeData/debugPC inputs.

Parameters:
- DEPTH, 4, side-result FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose arbitration before the pipeline is refused.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pipe_valid  in  1  pipeline writeback request
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- pipe_pc  in  32  PC of the writing instruction
- pipe_accept  out  1  combinational; pipeline write consumed this cycle
- side_valid  in  1  multi-cycle unit result valid
- side_ready  out  1  combinational; FIFO can accept
- side_addr  in  5  side destination register
- side_data  in  32  side result
- side_pc  in  32  PC of the originating instruction
- w_addr  out  5  to register file writeAddress; 0 = no write
- w_data  out  32  to register file writeData
- w_pc  out  32  to register file debugPC
- pending  out  32  bit i set while any FIFO entry targets register i; bit 0 always 0
- empty  out  1  FIFO empty

Behaviour:
- Reset: w_addr=0, w_data=0, w_pc=0; FIFO empty; pending=0; empty=1; starve counter=0.
- Arbitration (combinational each cycle):
  - Grant side when the FIFO is non-empty and either the starve counter equals STARVE_LIMIT or there is no pipeline write (pipe_valid=0 or pipe_addr=0).
  - Otherwise grant pipe if pipe_valid.
  - pipe_accept = pipe_valid & ~side_grant.
  - pipe_valid with pipe_addr=0 is accepted (pipe_accept=1) and produces no write.
- Stall rule: when pipe_accept=0 with pipe_valid=1, the pipeline holds addr/data/pc unchanged and retries next cycle.
- Output register: on each clk edge (not reset), w_addr/w_data/w_pc load the granted source. If nothing is granted, w_addr=0 and w_data/w_pc hold. Latency is exactly 1 cycle from grant to the register file inputs.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and pipe wins.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - side_ready = (count < DEPTH), computed from the registered count only. A pop in the same cycle does not raise side_ready.
  - Push when side_valid & side_ready.
  - side_addr=0 is handshaken (consumed) but not stored.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
  - Empty FIFO plus push in the same cycle: the entry is not granted that cycle; earliest output is 2 cycles after the push.
- pending: registered OR of one-hot(addr) over valid FIFO entries, updated on the same edge as push/pop. A register stays pending until its entry is popped, i.e. the same edge w_addr presents it.
- Ordering: pipe and side writes are never reordered within their own stream. Cross-stream ordering to the same register is enforced by the hazard unit via pending, not here.
- Reset mid-operation: FIFO contents discarded, w_addr=0 on the next edge, no partial write.

Test Plan:
- Idle after reset: pending=0, empty=1, w_addr=0, side_ready=1 for 5 cycles.
- Single pipe write (addr 8, data 0x1234, pc 0x3000) -> pipe_accept=1; next cycle w_addr=8, w_data=0x1234, w_pc=0x3000; following cycle w_addr=0.
- Side write (addr 3, data 0xDEADBEEF) while pipe idle -> pending[3]=1 after the push edge; w_addr=3 two cycles after push; pending[3]=0 on that same edge.
- Starvation: queue side addr 5, then hold pipe_valid continuously with addrs 9,10,11,12 -> pipe wins 3 cycles, 4th cycle pipe_accept=0 and side addr 5 is written; addr 12 is retried and written the next cycle.
- Full FIFO: push 4 side results (addrs 1..4) with pipe busy -> side_ready=0, pending=0x1E. A 5th side_valid is held until after the first pop.
- Zero-address and reset: side_addr=0 push -> consumed, empty stays 1, no write. Assert reset with 2 entries queued -> next edge w_addr=0, pending=0, empty=1.

Source files
------------

// File: rtl/grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_write_arbiter
// Purpose  : Merges pipeline writebacks and queued multi-cycle results into
//            the single registered register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
module grf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    output logic        pipe_accept,
    input  logic        side_valid,
    output logic        side_ready,
    input  logic [4:0]  side_addr,
    input  logic [31:0] side_data,
    input  logic [31:0] side_pc,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] w_pc,
    output logic [31:0] pending,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [31:0]      pending_q, pending_d;
    logic [4:0]       w_addr_q, w_addr_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [31:0]      w_pc_q, w_pc_d;

    logic w_fifo_empty;
    logic w_pipe_write;
    logic w_side_grant;
    logic w_push;

    always_comb begin
        w_fifo_empty = (count_q == '0);
        side_ready   = (count_q < C_DEPTH);
        w_pipe_write = pipe_valid && (pipe_addr != 5'd0);
        // Grant decisions use only registered FIFO state, so a fresh push
        // cannot bypass straight to the write port.
        w_side_grant = !w_fifo_empty && ((starve_q == C_STARVE_MAX) || !w_pipe_write);
        pipe_accept  = pipe_valid && !w_side_grant;
        w_push       = side_valid && side_ready && (side_addr != 5'd0);

        addr_d   = addr_q;
        data_d   = data_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (w_side_grant) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (w_push) begin
            addr_d[wr_ptr_q]  = side_addr;
            data_d[wr_ptr_q]  = side_data;
            pc_d[wr_ptr_q]    = side_pc;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        case ({w_push, w_side_grant})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (w_fifo_empty || w_side_grant) begin
            starve_d = '0;
        end else if (w_pipe_write && (starve_q != C_STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        pending_d = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i]) begin
                pending_d = pending_d | (32'd1 << addr_d[i]);
            end
        end

        w_addr_d = 5'd0;
        w_data_d = w_data_q;
        w_pc_d   = w_pc_q;
        if (w_side_grant) begin
            w_addr_d = addr_q[rd_ptr_q];
            w_data_d = data_q[rd_ptr_q];
            w_pc_d   = pc_q[rd_ptr_q];
        end else if (w_pipe_write) begin
            w_addr_d = pipe_addr;
            w_data_d = pipe_data;
            w_pc_d   = pipe_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= 32'd0;
            w_addr_q  <= 5'd0;
            w_data_q  <= 32'd0;
            w_pc_q    <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_pc_q    <= w_pc_d;
        end
    end

    // Payload storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        pc_q   <= pc_d;
    end

    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    assign w_pc    = w_pc_q;
    assign pending = pending_q;
    assign empty   = w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_write_arbiter
// Purpose  : Directed self-checking bench for grf_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        pipe_accept;
    logic        side_valid;
    logic        side_ready;
    logic [4:0]  side_addr;
    logic [31:0] side_data;
    logic [31:0] side_pc;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic [31:0] pending;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_valid  (pipe_valid),
        .pipe_addr   (pipe_addr),
        .pipe_data   (pipe_data),
        .pipe_pc     (pipe_pc),
        .pipe_accept (pipe_accept),
        .side_valid  (side_valid),
        .side_ready  (side_ready),
        .side_addr   (side_addr),
        .side_data   (side_data),
        .side_pc     (side_pc),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_pc        (w_pc),
        .pending     (pending),
        .empty       (empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next active edge; outputs settle 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        pipe_valid = v;
        pipe_addr  = a;
        pipe_data  = d;
        pipe_pc    = p;
    endtask

    task automatic drive_side(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        side_valid = v;
        side_addr  = a;
        side_data  = d;
        side_pc    = p;
    endtask

    logic [4:0] st_pa   [5] = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd12};
    logic       st_acc  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] st_w    [5] = '{5'd9, 5'd10, 5'd11, 5'd5, 5'd12};
    logic [4:0] drain_w [4] = '{5'd2, 5'd3, 5'd4, 5'd6};

    initial begin
        reset = 1'b1;
        drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            chk("idle_pending", pending, 32'd0);
            chk("idle_empty", {31'd0, empty}, 32'd1);
            chk("idle_waddr", {27'd0, w_addr}, 32'd0);
            chk("idle_sready", {31'd0, side_ready}, 32'd1);
            step();
        end
        chk("rst_wdata", w_data, 32'd0);
        chk("rst_wpc", w_pc, 32'd0);

        // Single pipeline write
        drive_pipe(1'b1, 5'd8, 32'h1234, 32'h3000);
        #1;
        chk("pipe_accept", {31'd0, pipe_accept}, 32'd1);
        step();
        drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        chk("pipe_waddr", {27'd0, w_addr}, 32'd8);
        chk("pipe_wdata", w_data, 32'h1234);
        chk("pipe_wpc", w_pc, 32'h3000);
        step();
        chk("pipe_after_waddr", {27'd0, w_addr}, 32'd0);
        chk("pipe_hold_wdata", w_data, 32'h1234);

        // Side write with the pipeline idle
        drive_side(1'b1, 5'd3, 32'hDEADBEEF, 32'h4000);
        #1;
        chk("side_ready", {31'd0, side_ready}, 32'd1);
        step();
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        chk("side_pending", pending, 32'h8);
        chk("side_notempty", {31'd0, empty}, 32'd0);
        chk("side_nobypass", {27'd0, w_addr}, 32'd0);
        step();
        chk("side_waddr", {27'd0, w_addr}, 32'd3);
        chk("side_wdata", w_data, 32'hDEADBEEF);
        chk("side_wpc", w_pc, 32'h4000);
        chk("side_pend_clr", pending, 32'd0);
        chk("side_empty", {31'd0, empty}, 32'd1);

        // Starvation: side addr 5 queued, pipeline streams 9..12
        drive_side(1'b1, 5'd5, 32'h55, 32'h5000);
        step();
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive_pipe(1'b1, st_pa[k], {27'd0, st_pa[k]}, 32'h100 + {27'd0, st_pa[k]});
            #1;
            chk("starve_accept", {31'd0, pipe_accept}, {31'd0, st_acc[k]});
            if (k < 3) chk("starve_pending", pending, 32'h20);
            step();
            chk("starve_waddr", {27'd0, w_addr}, {27'd0, st_w[k]});
        end
        chk("starve_wdata", w_data, 32'd12);
        chk("starve_pend_clr", pending, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        step();

        // Full FIFO with the pipeline continuously busy
        drive_pipe(1'b1, 5'd20, 32'h20, 32'h20);
        for (int k = 0; k < 4; k++) begin
            drive_side(1'b1, 5'(k + 1), 32'hA0 + 32'(k), 32'hB0 + 32'(k));
            #1;
            chk("full_sready", {31'd0, side_ready}, 32'd1);
            chk("full_paccept", {31'd0, pipe_accept}, 32'd1);
            step();
            chk("full_waddr", {27'd0, w_addr}, 32'd20);
        end
        drive_side(1'b1, 5'd6, 32'hA6, 32'hB6);
        #1;
        chk("full_sready0", {31'd0, side_ready}, 32'd0);
        chk("full_pending", pending, 32'h1E);
        chk("full_paccept0", {31'd0, pipe_accept}, 32'd0);
        step();
        chk("full_pop_waddr", {27'd0, w_addr}, 32'd1);
        chk("full_pop_wdata", w_data, 32'hA0);
        chk("full_pop_pend", pending, 32'h1C);
        #1;
        chk("full_sready1", {31'd0, side_ready}, 32'd1);
        chk("full_paccept1", {31'd0, pipe_accept}, 32'd1);
        step();
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        chk("full_push5_waddr", {27'd0, w_addr}, 32'd20);
        chk("full_push5_pend", pending, 32'h5C);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_waddr", {27'd0, w_addr}, {27'd0, drain_w[k]});
        end
        chk("drain_wpc", w_pc, 32'hB6);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_pending", pending, 32'd0);

        // Zero-address side push is consumed but never stored
        drive_side(1'b1, 5'd0, 32'hCAFE, 32'hF00D);
        #1;
        chk("zero_sready", {31'd0, side_ready}, 32'd1);
        step();
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        chk("zero_empty", {31'd0, empty}, 32'd1);
        chk("zero_pending", pending, 32'd0);
        step();
        chk("zero_waddr", {27'd0, w_addr}, 32'd0);

        // Reset with two entries queued behind a busy pipeline
        drive_pipe(1'b1, 5'd7, 32'h77, 32'h700);
        drive_side(1'b1, 5'd13, 32'hD, 32'hD00);
        step();
        drive_side(1'b1, 5'd14, 32'hE, 32'hE00);
        step();
        drive_side(1'b0, 5'd0, 32'd0, 32'd0);
        chk("prerst_pending", pending, 32'h6000);
        reset = 1'b1;
        step();
        chk("rst_waddr", {27'd0, w_addr}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_wdata_mid", w_data, 32'd0);
        reset = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'd0, 32'd0);
        step();
        chk("postrst_waddr", {27'd0, w_addr}, 32'd0);
        step();
        chk("postrst_waddr2", {27'd0, w_addr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
